// File: rtl/sim_event_sched.sv
// Round-robin arbiter that funnels $display/$stop/$finish events from NREQ sources into a
// registered-head FIFO, tracks RUN/STOPPED/HALTED and timestamps each event with a run-cycle count.
module sim_event_sched #(
    parameter int NREQ      = 4,
    parameter int DEPTH     = 8,
    parameter int PAYLOAD_W = 16,
    parameter int CYC_W     = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [2*NREQ-1:0]           req_type,
    input  logic [PAYLOAD_W*NREQ-1:0]   req_payload,
    output logic [NREQ-1:0]             req_ready,
    input  logic                        resume,
    output logic                        ev_valid,
    input  logic                        ev_ready,
    output logic [1:0]                  ev_type,
    output logic [2:0]                  ev_src,
    output logic [PAYLOAD_W-1:0]        ev_payload,
    output logic [CYC_W-1:0]            ev_cycle,
    output logic [$clog2(DEPTH):0]      level,
    output logic [1:0]                  state,
    output logic [7:0]                  err_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int EW = 2 + 3 + PAYLOAD_W + CYC_W;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_STOPPED = 2'b01,
        ST_HALTED  = 2'b10
    } state_e;

    state_e          state_q, state_d;
    logic [RW-1:0]   rr_q, rr_d;
    logic [AW:0]     wr_q, wr_d, rd_q, rd_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [7:0]      err_q, err_d;
    logic [EW-1:0]   mem_q [DEPTH];
    logic [EW-1:0]   entry_d;
    logic [EW-1:0]   head;

    logic [LW-1:0]   level_w;
    logic            empty, full, pop, grant_en, grant, push, is_rsvd, gnt_found;
    logic [RW-1:0]   gnt_idx, idx_w;
    logic [1:0]      gnt_type;
    logic [PAYLOAD_W-1:0] gnt_payload;

    assign level_w = wr_q - rd_q;
    assign empty   = (wr_q == rd_q);
    assign full    = (level_w == LW'(DEPTH));
    assign pop     = !empty && ev_ready;

    always_comb begin
        grant_en    = (state_q == ST_RUN) && (!full || pop);
        gnt_found   = 1'b0;
        gnt_idx     = '0;
        idx_w       = '0;
        gnt_type    = 2'b00;
        gnt_payload = '0;
        // Rotating priority: the first valid requester at or after rr_q wins.
        for (int k = 0; k < NREQ; k++) begin
            idx_w = RW'((int'(rr_q) + k) % NREQ);
            if (!gnt_found && req_valid[idx_w]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx_w;
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_idx == RW'(k)) begin
                gnt_type    = req_type[2*k +: 2];
                gnt_payload = req_payload[PAYLOAD_W*k +: PAYLOAD_W];
            end
        end
        grant     = grant_en && gnt_found;
        req_ready = grant ? (NREQ'(1) << gnt_idx) : '0;
        is_rsvd   = (gnt_type == 2'b11);
        push      = grant && !is_rsvd;
        entry_d   = {gnt_type, 3'(gnt_idx), gnt_payload, cyc_q};

        wr_d  = push ? wr_q + 1'b1 : wr_q;
        rd_d  = pop ? rd_q + 1'b1 : rd_q;
        rr_d  = rr_q;
        if (grant) begin
            rr_d = (gnt_idx == RW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
        err_d = (grant && is_rsvd && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
        cyc_d = (state_q == ST_RUN && cyc_q != '1) ? cyc_q + 1'b1 : cyc_q;

        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (grant && gnt_type == 2'b01) state_d = ST_STOPPED;
                else if (grant && gnt_type == 2'b10) state_d = ST_HALTED;
            end
            ST_STOPPED: if (resume) state_d = ST_RUN;
            ST_HALTED:  state_d = ST_HALTED;
            default:    state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            rr_q    <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cyc_q   <= '0;
            err_q   <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cyc_q   <= cyc_d;
            err_q   <= err_d;
            // When full with a pop, this slot is the one being read out this cycle.
            if (push) mem_q[wr_q[AW-1:0]] <= entry_d;
        end
    end

    assign head       = mem_q[rd_q[AW-1:0]];
    assign ev_valid   = !empty;
    assign ev_type    = head[EW-1 -: 2];
    assign ev_src     = head[EW-3 -: 3];
    assign ev_payload = head[CYC_W +: PAYLOAD_W];
    assign ev_cycle   = head[0 +: CYC_W];
    assign level      = level_w;
    assign state      = state_q;
    assign err_cnt    = err_q;
endmodule

// File: tb/tb_sim_event_sched.sv
// Directed bench for sim_event_sched: stimulus pushes hand-computed events into a scoreboard
// queue, and a negedge monitor pops and compares every event the host drains.
module tb_sim_event_sched;
    localparam int NREQ = 4;
    localparam int DEPTH = 8;
    localparam int PW = 16;
    localparam int CW = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NREQ-1:0]  req_valid = '0;
    logic [2*NREQ-1:0] req_type = '0;
    logic [PW*NREQ-1:0] req_payload = '0;
    logic [NREQ-1:0]  req_ready;
    logic             resume = 1'b0;
    logic             ev_valid;
    logic             ev_ready = 1'b0;
    logic [1:0]       ev_type;
    logic [2:0]       ev_src;
    logic [PW-1:0]    ev_payload;
    logic [CW-1:0]    ev_cycle;
    logic [3:0]       level;
    logic [1:0]       state;
    logic [7:0]       err_cnt;

    typedef struct packed {
        logic [1:0]    t;
        logic [2:0]    s;
        logic [PW-1:0] p;
        logic [CW-1:0] c;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    sim_event_sched #(.NREQ(NREQ), .DEPTH(DEPTH), .PAYLOAD_W(PW), .CYC_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_type(req_type),
        .req_payload(req_payload), .req_ready(req_ready), .resume(resume),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_type(ev_type), .ev_src(ev_src),
        .ev_payload(ev_payload), .ev_cycle(ev_cycle), .level(level), .state(state),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: a pop happens at the next posedge whenever valid & ready here.
    always @(negedge clk) begin : monitor
        ev_t e;
        if (rst_n && ev_valid && ev_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event: actual type=%0d src=%0d payload=%h cycle=%0d, required no event",
                         ev_type, ev_src, ev_payload, ev_cycle);
            end else begin
                e = exp_q.pop_front();
                if ({ev_type, ev_src, ev_payload, ev_cycle} !== e) begin
                    n_bad++;
                    $display("FAIL event: actual type=%0d src=%0d payload=%h cycle=%0d, required type=%0d src=%0d payload=%h cycle=%0d",
                             ev_type, ev_src, ev_payload, ev_cycle, e.t, e.s, e.p, e.c);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] t, input logic [2:0] s, input logic [PW-1:0] p,
                            input logic [CW-1:0] c);
        ev_t e;
        e.t = t; e.s = s; e.p = p; e.c = c;
        exp_q.push_back(e);
    endtask

    task automatic set_req(input int i, input logic v, input logic [1:0] t, input logic [PW-1:0] p);
        req_valid[i] = v;
        req_type[2*i +: 2] = t;
        req_payload[PW*i +: PW] = p;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    // Leaves the bench one cycle into the run with reset released and cycle counter 0.
    task automatic do_reset();
        nxt();
        rst_n = 1'b0;
        req_valid = '0; req_type = '0; req_payload = '0;
        ev_ready = 1'b0; resume = 1'b0;
        exp_q.delete();
        repeat (2) nxt();
        rst_n = 1'b1;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        ev_ready = 1'b1;
        req_valid = '0;
        neg();
        while (level != 0 && n < 40) begin
            neg();
            n++;
        end
        chk({nm, "_drained_level"}, level, 0);
        chk({nm, "_scoreboard_left"}, exp_q.size(), 0);
    endtask

    logic [3:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [2:0] rr_src [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};

    initial begin
        // Power-on reset state
        do_reset();
        neg();
        chk("rst_level", level, 0);
        chk("rst_ev_valid", ev_valid, 0);
        chk("rst_state", state, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_ev_cycle", ev_cycle, 0);

        // Round-robin over all requesters
        do_reset();
        ev_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 2'b00, PW'(16'hA0 + i));
        for (int k = 0; k < 5; k++) begin
            if (k > 0) nxt();
            neg();
            chk("rr_grant", req_ready, rr_exp[k]);
            push_exp(2'b00, rr_src[k], PW'(16'hA0) + PW'(rr_src[k]), CW'(k));
        end
        nxt();
        drain("rr");

        // Reset mid-stream with three events buffered
        do_reset();
        set_req(0, 1'b1, 2'b00, 16'h0055);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) nxt();
            neg();
            chk("midrst_grant", req_ready, 4'b0001);
        end
        nxt();
        req_valid = '0;
        neg();
        chk("midrst_level_before", level, 3);
        chk("midrst_head_cycle", ev_cycle, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_level", level, 0);
        chk("midrst_ev_valid", ev_valid, 0);
        chk("midrst_state", state, 0);
        chk("midrst_ev_cycle", ev_cycle, 0);
        nxt();
        chk("midrst_level_edge", level, 0);

        // Full FIFO, then one pop with a same-cycle push
        do_reset();
        for (int k = 0; k < DEPTH; k++) begin
            if (k > 0) nxt();
            set_req(0, 1'b1, 2'b00, PW'(16'h300 + k));
            neg();
            chk("full_fill_grant", req_ready, 4'b0001);
            push_exp(2'b00, 3'd0, PW'(16'h300 + k), CW'(k));
        end
        nxt();
        set_req(0, 1'b1, 2'b00, 16'h0308);
        neg();
        chk("full_no_grant", req_ready, 0);
        chk("full_level", level, 8);
        nxt();
        neg();
        chk("full_no_grant2", req_ready, 0);
        nxt();
        ev_ready = 1'b1;
        set_req(0, 1'b1, 2'b00, 16'h030A);
        neg();
        chk("full_pop_push_grant", req_ready, 4'b0001);
        chk("full_pop_push_level", level, 8);
        push_exp(2'b00, 3'd0, 16'h030A, 32'd10);
        nxt();
        ev_ready = 1'b0;
        neg();
        chk("full_level_after_pop_push", level, 8);
        chk("full_no_grant3", req_ready, 0);
        nxt();
        drain("full");

        // STOP at cycle 5, hold, resume
        do_reset();
        ev_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) nxt();
            set_req(0, 1'b1, 2'b00, PW'(16'h400 + k));
            neg();
            chk("stop_pre_grant", req_ready, 4'b0001);
            push_exp(2'b00, 3'd0, PW'(16'h400 + k), CW'(k));
        end
        nxt();
        set_req(0, 1'b1, 2'b00, 16'h0410);
        set_req(1, 1'b1, 2'b01, 16'h0411);
        set_req(2, 1'b1, 2'b00, 16'h0412);
        set_req(3, 1'b1, 2'b00, 16'h0413);
        neg();
        chk("stop_grant", req_ready, 4'b0010);
        push_exp(2'b01, 3'd1, 16'h0411, 32'd5);
        for (int k = 0; k < 3; k++) begin
            nxt();
            if (k == 2) resume = 1'b1;
            neg();
            chk("stop_state", state, 1);
            chk("stop_no_grant", req_ready, 0);
        end
        nxt();
        resume = 1'b0;
        set_req(1, 1'b1, 2'b00, 16'h0421);
        neg();
        chk("resume_state", state, 0);
        chk("resume_grant", req_ready, 4'b0100);
        push_exp(2'b00, 3'd2, 16'h0412, 32'd6);
        nxt();
        drain("stop");

        // FINISH from req2 against DISPLAY from req3 with rr_ptr at 2
        do_reset();
        ev_ready = 1'b1;
        set_req(1, 1'b1, 2'b00, 16'h0501);
        neg();
        chk("fin_pre_grant", req_ready, 4'b0010);
        push_exp(2'b00, 3'd1, 16'h0501, 32'd0);
        nxt();
        set_req(1, 1'b0, 2'b00, 16'h0000);
        set_req(2, 1'b1, 2'b10, 16'h0502);
        set_req(3, 1'b1, 2'b00, 16'h0503);
        neg();
        chk("fin_grant", req_ready, 4'b0100);
        push_exp(2'b10, 3'd2, 16'h0502, 32'd1);
        for (int k = 0; k < 4; k++) begin
            nxt();
            resume = (k == 1);
            neg();
            if (k == 0) chk("fin_head_type", ev_type, 2);
            chk("fin_state", state, 2);
            chk("fin_no_grant", req_ready, 0);
        end
        nxt();
        resume = 1'b0;
        drain("finish");

        // Reserved type, 300 times
        do_reset();
        ev_ready = 1'b1;
        set_req(0, 1'b1, 2'b11, 16'h0600);
        for (int k = 0; k < 300; k++) begin
            if (k > 0) nxt();
            neg();
            if (k == 0) chk("rsvd_grant", req_ready, 4'b0001);
            if (k == 10) chk("rsvd_err_10", err_cnt, 10);
            if (k == 255) chk("rsvd_err_255", err_cnt, 255);
            if (k % 50 == 0) chk("rsvd_level", level, 0);
        end
        nxt();
        req_valid = '0;
        neg();
        chk("rsvd_err_sat", err_cnt, 255);
        chk("rsvd_level_end", level, 0);
        chk("rsvd_state", state, 0);
        chk("rsvd_scoreboard_left", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
